core_mem_responder: RTL and testbench

//  Data-memory responder on the Core load/store port (enable_M/addr_M/wr_data_M -> rd_data_M/ready_M).

---
 rtl/core_mem_responder.sv | 116 +++++++++++
 tb/tb_core_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Data-memory responder for the Core load/store port. A rising request on
//   enable_M is latched, held in service for LATENCY cycles, then performed
//   against an internal RAM while ready_M returns high.
//   Optional feature macro: MEM_RESP_ERR_EN (adds err_M, flags illegal ops).
module core_mem_responder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        enable_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [DATA_W-1:0] wr_data_M,
  output logic [DATA_W-1:0] rd_data_M,
  output logic              ready_M,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
`ifdef MEM_RESP_ERR_EN
  ,
  output logic              err_M
`endif
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state;
  logic [1:0]        en_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;

  logic accept;
  logic done;
  logic store_fire;

  // A request is only taken on its rising edge so a held enable is never re-accepted
  assign accept     = (state == IDLE) && (enable_M != 2'b00) && (en_q == 2'b00);
  assign done       = (state == BUSY) && (cnt == 4'd0);
  // A reset landing on the completion edge cancels the store
  assign store_fire = reset && done && (op_q == OP_STORE);

  // RAM write ports; the store is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
    if (store_fire) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Request FSM: latch on accept, count down the latency, complete and go idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ready_M   <= 1'b1;
      rd_data_M <= '0;
      en_q      <= 2'b00;
      op_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= 4'd0;
`ifdef MEM_RESP_ERR_EN
      err_M     <= 1'b0;
`endif
    end else begin
      en_q <= enable_M;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= enable_M;
            addr_q  <= addr_M;
            wdata_q <= wr_data_M;
            cnt     <= CNT_INIT;
            ready_M <= 1'b0;
            state   <= BUSY;
`ifdef MEM_RESP_ERR_EN
            err_M   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_q == OP_LOAD) begin
              rd_data_M <= mem[addr_q];
            end
`ifdef MEM_RESP_ERR_EN
            if (op_q == 2'b11) begin
              err_M <= 1'b1;
            end
`endif
            ready_M <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder
//   Directed bench for core_mem_responder: one instance at LATENCY=1 for the
//   main load/store table and corner cases, one at LATENCY=4 for latching.
//   Build with MEM_RESP_ERR_EN defined to also exercise err_M.
module tb_core_mem_responder;

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] enable_M;
  logic [7:0] addr_M;
  logic [7:0] wr_data_M;
  logic [7:0] rd_data_M;
  logic       ready_M;
  logic       init_we;
  logic [7:0] init_addr;
  logic [7:0] init_data;

  logic [1:0] en4;
  logic [7:0] addr4;
  logic [7:0] wd4;
  logic [7:0] rd4;
  logic       rdy4;

`ifdef MEM_RESP_ERR_EN
  logic err_M;
  logic err4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable_M  (enable_M),
    .addr_M    (addr_M),
    .wr_data_M (wr_data_M),
    .rd_data_M (rd_data_M),
    .ready_M   (ready_M),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
`ifdef MEM_RESP_ERR_EN
    ,
    .err_M     (err_M)
`endif
  );

  core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .enable_M  (en4),
    .addr_M    (addr4),
    .wr_data_M (wd4),
    .rd_data_M (rd4),
    .ready_M   (rdy4),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
`ifdef MEM_RESP_ERR_EN
    ,
    .err_M     (err4)
`endif
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Backdoor write into both instances' RAM
  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  // One full request on the LATENCY=1 instance; optionally fires a backdoor
  // write to the same address on the completion edge. Enable is dropped at the end.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                               input bit collide, input logic [7:0] cdata, output int low_cycles);
    @(negedge clk);
    enable_M  = op;
    addr_M    = a;
    wr_data_M = wd;
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_M === 1'b1) break;
      low_cycles++;
      if (collide && low_cycles == 1) begin
        init_we   = 1'b1;
        init_addr = a;
        init_data = cdata;
      end else begin
        init_we = 1'b0;
      end
    end
    init_we  = 1'b0;
    enable_M = 2'b00;
  endtask

  // One request on the LATENCY=4 instance; optionally scrambles inputs while busy
  task automatic run4(input logic [1:0] op, input logic [7:0] a, input bit scramble, output int low_cycles);
    @(negedge clk);
    en4   = op;
    addr4 = a;
    wd4   = 8'h99;
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy4 === 1'b1) break;
      low_cycles++;
      if (scramble) begin
        en4   = 2'b10;
        addr4 = 8'd20;
        wd4   = 8'h66;
      end
    end
    en4 = 2'b00;
  endtask

  vec_t vecs [8];
  int   low;

  initial begin
    vecs[0] = '{op: 2'b10, addr: 8'd3,   wdata: 8'hA5, exp_rd: 8'h08};
    vecs[1] = '{op: 2'b01, addr: 8'd3,   wdata: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{op: 2'b10, addr: 8'd200, wdata: 8'h3C, exp_rd: 8'hA5};
    vecs[3] = '{op: 2'b01, addr: 8'd255, wdata: 8'h00, exp_rd: 8'hEE};
    vecs[4] = '{op: 2'b01, addr: 8'd200, wdata: 8'h00, exp_rd: 8'h3C};
    vecs[5] = '{op: 2'b10, addr: 8'd0,   wdata: 8'hFF, exp_rd: 8'h3C};
    vecs[6] = '{op: 2'b01, addr: 8'd0,   wdata: 8'h00, exp_rd: 8'hFF};
    vecs[7] = '{op: 2'b11, addr: 8'd0,   wdata: 8'h12, exp_rd: 8'hFF};

    reset     = 1'b0;
    enable_M  = 2'b00;
    addr_M    = '0;
    wr_data_M = '0;
    init_we   = 1'b0;
    init_addr = '0;
    init_data = '0;
    en4       = 2'b00;
    addr4     = '0;
    wd4       = '0;

    // Preload under reset; RAM must survive reset
    backdoor(8'd3,   8'h5A);
    backdoor(8'd255, 8'hEE);
    backdoor(8'd7,   8'h01);
    backdoor(8'd10,  8'h11);
    backdoor(8'd20,  8'h22);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_ready", 32'(ready_M), 32'h1);
    checkOutput("reset_rd", 32'(rd_data_M), 32'h0);
    checkOutput("reset_ready4", 32'(rdy4), 32'h1);
    checkOutput("reset_rd4", 32'(rd4), 32'h0);
`ifdef MEM_RESP_ERR_EN
    checkOutput("reset_err", 32'(err_M), 32'h0);
`endif
    applyStimulus(2'b01, 8'd3, 8'h00, 1'b0, 8'h00, low);
    checkOutput("preload_kept_rd", 32'(rd_data_M), 32'h5A);
    checkOutput("preload_kept_low", 32'(low), 32'd1);

    // Basic load after backdoor
    backdoor(8'd3, 8'h08);
    applyStimulus(2'b01, 8'd3, 8'h00, 1'b0, 8'h00, low);
    checkOutput("load3_low", 32'(low), 32'd1);
    checkOutput("load3_rd", 32'(rd_data_M), 32'h08);
    checkOutput("load3_ready", 32'(ready_M), 32'h1);

    // Table of loads, stores and an illegal op
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h00, low);
      checkOutput($sformatf("vec%0d_low", i), 32'(low), 32'd1);
      checkOutput($sformatf("vec%0d_rd", i), 32'(rd_data_M), 32'(vecs[i].exp_rd));
    end

    // Held enable: one access only, RAM change during hold must not show up
    applyStimulus(2'b01, 8'd3, 8'h00, 1'b0, 8'h00, low);
    @(negedge clk);
    enable_M = 2'b01;
    addr_M   = 8'd3;
    low = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready_M !== 1'b1) low++;
      if (i == 3) begin
        init_we   = 1'b1;
        init_addr = 8'd3;
        init_data = 8'h77;
      end else begin
        init_we = 1'b0;
      end
    end
    checkOutput("hold_low_total", 32'(low), 32'd1);
    checkOutput("hold_rd", 32'(rd_data_M), 32'hA5);
    enable_M = 2'b00;
    applyStimulus(2'b01, 8'd3, 8'h00, 1'b0, 8'h00, low);
    checkOutput("hold_after_rd", 32'(rd_data_M), 32'h77);

    // Store vs backdoor on the same edge: store wins
    applyStimulus(2'b10, 8'd5, 8'h77, 1'b1, 8'h33, low);
    applyStimulus(2'b01, 8'd5, 8'h00, 1'b0, 8'h00, low);
    checkOutput("collide_store_rd", 32'(rd_data_M), 32'h77);
    // Load vs backdoor on the same edge: old data returned, new data lands
    applyStimulus(2'b01, 8'd5, 8'h00, 1'b1, 8'h44, low);
    checkOutput("collide_load_old", 32'(rd_data_M), 32'h77);
    applyStimulus(2'b01, 8'd5, 8'h00, 1'b0, 8'h00, low);
    checkOutput("collide_load_new", 32'(rd_data_M), 32'h44);

    // LATENCY=4: inputs changed while busy are ignored
    run4(2'b01, 8'd10, 1'b1, low);
    checkOutput("lat4_low", 32'(low), 32'd4);
    checkOutput("lat4_rd", 32'(rd4), 32'h11);
    run4(2'b01, 8'd20, 1'b0, low);
    checkOutput("lat4_no_store_rd", 32'(rd4), 32'h22);
    checkOutput("lat4_low2", 32'(low), 32'd4);

    // Reset while a store is in service drops it
    @(negedge clk);
    enable_M  = 2'b10;
    addr_M    = 8'd7;
    wr_data_M = 8'hBB;
    @(negedge clk);
    checkOutput("rst_busy_ready", 32'(ready_M), 32'h0);
    reset    = 1'b0;
    enable_M = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst_mid_ready", 32'(ready_M), 32'h1);
    checkOutput("rst_mid_rd", 32'(rd_data_M), 32'h0);
    applyStimulus(2'b01, 8'd7, 8'h00, 1'b0, 8'h00, low);
    checkOutput("rst_mid_ram7", 32'(rd_data_M), 32'h01);

    // Illegal request: completes after the latency, no data change
    applyStimulus(2'b11, 8'd7, 8'h55, 1'b0, 8'h00, low);
    checkOutput("illegal_low", 32'(low), 32'd1);
    checkOutput("illegal_rd", 32'(rd_data_M), 32'h01);
    checkOutput("illegal_ready", 32'(ready_M), 32'h1);
`ifdef MEM_RESP_ERR_EN
    checkOutput("illegal_err_set", 32'(err_M), 32'h1);
`endif
    applyStimulus(2'b01, 8'd7, 8'h00, 1'b0, 8'h00, low);
    checkOutput("illegal_ram7", 32'(rd_data_M), 32'h01);
`ifdef MEM_RESP_ERR_EN
    checkOutput("illegal_err_clr", 32'(err_M), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
